edge_debouncer: RTL and testbench
=================================

EDGE_DEBOUNCER -- requirements
Module: edge_debouncer

Interface
REQ-001 SHALL have parameter STABLE, default 4, consecutive equal samples required to accept a level change; legal range 2..255.
REQ-002 SHALL have parameter CW, default 8, width of the accepted-edge counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port D  input  1  raw level from the upstream DFF Q output, synchronous to clk.
REQ-006 SHALL have port en  input  1  enable; when low, no edge is qualified.
REQ-007 SHALL have port Q  output  1  debounced level, registered.
REQ-008 SHALL have port QBar  output  1  complement of Q at all times.
REQ-009 SHALL have port rise  output  1  one-cycle pulse when Q goes 0->1.
REQ-010 SHALL have port fall  output  1  one-cycle pulse when Q goes 1->0.
REQ-011 SHALL have port busy  output  1  high while a candidate change is being qualified.
REQ-012 SHALL have port edges  output  CW  count of accepted edges, rise plus fall.

Function
REQ-013 SHALL implement an FSM with states S_LOW, S_WAIT_HIGH, S_HIGH and S_WAIT_LOW, plus a stability counter cnt of 8 bits.
REQ-014 In S_LOW, with en=1 and D=1, SHALL go to S_WAIT_HIGH with cnt=1; otherwise SHALL hold.
REQ-015 In S_WAIT_HIGH, with D=0, SHALL return to S_LOW with cnt=0 and no pulse; the glitch is rejected.
REQ-016 In S_WAIT_HIGH, with D=1 and cnt=STABLE-1, SHALL go to S_HIGH, set Q=1, assert rise for exactly one cycle and increment edges.
REQ-017 In S_WAIT_HIGH, with D=1 and cnt<STABLE-1, SHALL increment cnt.
REQ-018 S_HIGH and S_WAIT_LOW SHALL mirror REQ-014..017 with D inverted, producing fall and Q=0.
REQ-019 Latency: Q SHALL change on the rising edge that samples the STABLE-th consecutive opposite-level value of D; rise or fall SHALL be high during the following cycle only.
REQ-020 busy SHALL be 1 exactly when the state is S_WAIT_HIGH or S_WAIT_LOW.
REQ-021 en=0 in a WAIT state SHALL abort to the prior stable state with cnt=0 and no pulse.
REQ-022 en=0 in a stable state SHALL hold state, Q and edges.
REQ-023 rise and fall SHALL never be asserted in the same cycle, and SHALL never be asserted on consecutive cycles.
REQ-024 edges SHALL increment by 1 per accepted edge, modulo 2^CW, wrapping silently from all-ones to 0.
REQ-025 Q, QBar, rise, fall, busy and edges SHALL all be registered outputs with no combinational path from D or en.

Reset
REQ-026 rst=1 at a rising edge SHALL force state=S_LOW, cnt=0, Q=0, QBar=1, rise=0, fall=0, busy=0 and edges=0, regardless of D or en.
REQ-027 rst SHALL take priority over every FSM transition, including a reset asserted mid-qualification or on the qualifying edge itself.
REQ-028 Before the first reset, output values are unspecified; the bench SHALL apply reset before checking.

Verification (STABLE=4, CW=8 unless noted)
REQ-029 Reset: rst=1 for 2 cycles with D=1 -> Q=0, QBar=1, rise=0, fall=0, busy=0, edges=0.
REQ-030 Rise: D=1 held for 6 edges, en=1 -> busy=1 after edge 1; Q=1 after edge 4; rise=1 for one cycle only; busy=0; edges=1.
REQ-031 Glitch: D=1 for 3 edges then D=0 -> Q stays 0, no rise, busy returns to 0, edges=0.
REQ-032 Fall: from Q=1, D=0 for 4 edges -> Q=0 and QBar=1 after edge 4; fall pulses once; edges=2.
REQ-033 Wrap and enable: with CW=2, accept 4 edges -> edges returns to 0; en=0 during S_WAIT_HIGH -> state returns to S_LOW with no rise.
REQ-034 Mid-operation reset: rst=1 on the edge where cnt=3 in S_WAIT_HIGH -> no rise, and all reset values hold on the next cycle.

Source files
------------

// File: rtl/edge_debouncer.sv
// edge_debouncer
//   Qualifies level changes on D: a new level is accepted only after STABLE
//   consecutive samples at that level with en high. Accepted changes update
//   Q/QBar, emit a one-cycle rise or fall pulse and bump the edges counter.
//
// Ports
//   clk   : clock; all state updates on the rising edge
//   rst   : synchronous active-high reset
//   D     : raw level, synchronous to clk
//   en    : enable; low aborts any qualification in progress
//   Q     : debounced level (registered)
//   QBar  : complement of Q (registered)
//   rise  : one-cycle pulse after Q goes 0->1
//   fall  : one-cycle pulse after Q goes 1->0
//   busy  : high while a candidate change is being qualified
//   edges : count of accepted edges, wraps modulo 2^CW
module edge_debouncer #(
  parameter int STABLE = 4,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          D,
  input  logic          en,
  output logic          Q,
  output logic          QBar,
  output logic          rise,
  output logic          fall,
  output logic          busy,
  output logic [CW-1:0] edges
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  // cnt holds the number of consecutive opposite-level samples seen so far;
  // the sample that would make it STABLE is the qualifying one.
  localparam logic [7:0] LAST = 8'(STABLE - 1);

  state_t          state, state_n;
  logic [7:0]      cnt, cnt_n;
  logic            q_n, rise_n, fall_n, busy_n;
  logic [CW-1:0]   edges_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = Q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    edges_n = edges;
    case (state)
      S_LOW: begin
        if (en && D) begin
          state_n = S_WAIT_HIGH;
          cnt_n   = 8'd1;
        end
      end
      S_WAIT_HIGH: begin
        if (!en || !D) begin
          // glitch or disable: drop the candidate without a pulse
          state_n = S_LOW;
          cnt_n   = 8'd0;
        end else if (cnt == LAST) begin
          state_n = S_HIGH;
          cnt_n   = 8'd0;
          q_n     = 1'b1;
          rise_n  = 1'b1;
          edges_n = edges + CW'(1);
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_HIGH: begin
        if (en && !D) begin
          state_n = S_WAIT_LOW;
          cnt_n   = 8'd1;
        end
      end
      S_WAIT_LOW: begin
        if (!en || D) begin
          state_n = S_HIGH;
          cnt_n   = 8'd0;
        end else if (cnt == LAST) begin
          state_n = S_LOW;
          cnt_n   = 8'd0;
          q_n     = 1'b0;
          fall_n  = 1'b1;
          edges_n = edges + CW'(1);
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = S_LOW;
        cnt_n   = 8'd0;
        q_n     = 1'b0;
      end
    endcase
    // busy is registered from the next state so it tracks the state register
    busy_n = (state_n == S_WAIT_HIGH) || (state_n == S_WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= 8'd0;
      Q     <= 1'b0;
      QBar  <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
      edges <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      Q     <= q_n;
      QBar  <= ~q_n;
      rise  <= rise_n;
      fall  <= fall_n;
      busy  <= busy_n;
      edges <= edges_n;
    end
  end

endmodule

// File: tb/tb_edge_debouncer.sv
// Bench for edge_debouncer: fixed vector table, hand-written corner
// sequences and randomized traffic, all checked against a run-length model.
module tb_edge_debouncer;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       D   = 1'b1;
  logic       en  = 1'b1;
  logic       Q, QBar, rise, fall, busy;
  logic [7:0] edges;
  logic       Q2, QBar2, rise2, fall2, busy2;
  logic [1:0] edges2;

  always #5 clk = ~clk;

  edge_debouncer #(.STABLE(STABLE), .CW(8)) dut (
    .clk(clk), .rst(rst), .D(D), .en(en),
    .Q(Q), .QBar(QBar), .rise(rise), .fall(fall), .busy(busy), .edges(edges)
  );

  // narrow counter copy to exercise wrap
  edge_debouncer #(.STABLE(STABLE), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .D(D), .en(en),
    .Q(Q2), .QBar(QBar2), .rise(rise2), .fall(fall2), .busy(busy2), .edges(edges2)
  );

  int tests = 0;
  int fails = 0;

  // reference model: length of the current run of opposite-level samples
  int m_q = 0, m_run = 0, m_rise = 0, m_fall = 0, m_edges = 0;
  int prev_pulse = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int r, input int e, input int d);
    if (r != 0) begin
      m_q = 0; m_run = 0; m_rise = 0; m_fall = 0; m_edges = 0;
    end else begin
      m_rise = 0; m_fall = 0;
      if (e == 0)       m_run = 0;
      else if (d != m_q) begin
        m_run++;
        if (m_run == STABLE) begin
          m_q = d; m_rise = d; m_fall = 1 - d; m_edges++; m_run = 0;
        end
      end else          m_run = 0;
    end
  endtask

  // apply one cycle of inputs, advance the model, compare every output
  task automatic step(input logic r, input logic e, input logic d);
    rst = r; en = e; D = d;
    @(posedge clk);
    model_step(int'(r), int'(e), int'(d));
    #1;
    chk("q",      int'(Q),     m_q);
    chk("qbar",   int'(QBar),  1 - m_q);
    chk("rise",   int'(rise),  m_rise);
    chk("fall",   int'(fall),  m_fall);
    chk("busy",   int'(busy),  (m_run != 0) ? 1 : 0);
    chk("edges",  int'(edges), m_edges % 256);
    chk("q_cw2",  int'(Q2),    m_q);
    chk("edges_cw2", int'(edges2), m_edges % 4);
    chk("pulse_excl", int'(rise & fall), 0);
    chk("pulse_gap",  (prev_pulse != 0 && (rise || fall)) ? 1 : 0, 0);
    prev_pulse = int'(rise | fall);
  endtask

  typedef struct {
    logic r, e, d;
    logic q, ri, fa, bz;
    int   ed;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // reset with D=1
    tbl[0]  = '{1,1,1, 0,0,0,0, 0};
    tbl[1]  = '{1,1,1, 0,0,0,0, 0};
    // glitch: three highs then low
    tbl[2]  = '{0,1,1, 0,0,0,1, 0};
    tbl[3]  = '{0,1,1, 0,0,0,1, 0};
    tbl[4]  = '{0,1,1, 0,0,0,1, 0};
    tbl[5]  = '{0,1,0, 0,0,0,0, 0};
    // rise: six highs
    tbl[6]  = '{0,1,1, 0,0,0,1, 0};
    tbl[7]  = '{0,1,1, 0,0,0,1, 0};
    tbl[8]  = '{0,1,1, 0,0,0,1, 0};
    tbl[9]  = '{0,1,1, 1,1,0,0, 1};
    tbl[10] = '{0,1,1, 1,0,0,0, 1};
    tbl[11] = '{0,1,1, 1,0,0,0, 1};
    // fall: five lows
    tbl[12] = '{0,1,0, 1,0,0,1, 1};
    tbl[13] = '{0,1,0, 1,0,0,1, 1};
    tbl[14] = '{0,1,0, 1,0,0,1, 1};
    tbl[15] = '{0,1,0, 0,0,1,0, 2};
    tbl[16] = '{0,1,0, 0,0,0,0, 2};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d);
      chk("tbl_q",     int'(Q),     int'(tbl[i].q));
      chk("tbl_qbar",  int'(QBar),  int'(!tbl[i].q));
      chk("tbl_rise",  int'(rise),  int'(tbl[i].ri));
      chk("tbl_fall",  int'(fall),  int'(tbl[i].fa));
      chk("tbl_busy",  int'(busy),  int'(tbl[i].bz));
      chk("tbl_edges", int'(edges), tbl[i].ed);
    end

    // enable dropped during qualification aborts without a pulse
    step(0,1,1); step(0,1,1);
    chk("en_busy_before", int'(busy), 1);
    step(0,0,1);
    chk("en_abort_busy", int'(busy), 0);
    chk("en_abort_q",    int'(Q),    0);
    chk("en_abort_rise", int'(rise), 0);
    step(0,0,1); step(0,0,1);
    chk("en_hold_q",     int'(Q),     0);
    chk("en_hold_edges", int'(edges), 2);
    for (int i = 0; i < 4; i++) step(0,1,1);
    chk("en_resume_rise", int'(rise), 1);
    chk("en_resume_edges", int'(edges), 3);

    // reset on the would-be qualifying edge
    step(1,1,0); step(0,1,1); step(0,1,1); step(0,1,1);
    step(1,1,1);
    chk("midrst_q",    int'(Q),    0);
    chk("midrst_rise", int'(rise), 0);
    chk("midrst_busy", int'(busy), 0);
    step(0,0,1);
    chk("midrst_hold_q",     int'(Q),     0);
    chk("midrst_hold_rise",  int'(rise),  0);
    chk("midrst_hold_edges", int'(edges), 0);

    // wrap of the 2-bit counter after four accepted edges
    step(1,1,0);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < STABLE + 1; i++) step(0, 1, (k % 2 == 0) ? 1'b1 : 1'b0);
    chk("wrap_edges_cw2", int'(edges2), 0);
    chk("wrap_edges_cw8", int'(edges),  4);

    // randomized traffic
    begin
      logic d_cur;
      d_cur = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(4, 0) == 0) d_cur = ~d_cur;
        step(($urandom_range(99, 0) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(7, 0) != 0) ? 1'b1 : 1'b0,
             d_cur);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
